// File: rtl/tetris_input_pkg.sv
// Shared definitions for the Tetris input-conditioning block.
//   - HID keycodes for the five game commands, "no command" and keyboard rollover
//   - rpt_state_t: states of the per-key delayed-auto-shift / repeat unit
//   - key_in_slots(): true when a keycode appears in any of the four HID slots
package tetris_input_pkg;

    localparam logic [7:0] KC_LEFT     = 8'h04;
    localparam logic [7:0] KC_RIGHT    = 8'h07;
    localparam logic [7:0] KC_SOFT     = 8'h16;
    localparam logic [7:0] KC_ROT      = 8'h1A;
    localparam logic [7:0] KC_HARD     = 8'h2C;
    localparam logic [7:0] KC_NONE     = 8'h00;
    localparam logic [7:0] KC_ROLLOVER = 8'h01;

    typedef enum logic [1:0] {
        IDLE,
        DAS,
        REPEAT
    } rpt_state_t;

    function automatic logic key_in_slots(input logic [31:0] kc, input logic [7:0] code);
        return (kc[7:0] == code) || (kc[15:8] == code) ||
               (kc[23:16] == code) || (kc[31:24] == code);
    endfunction

endpackage

// File: rtl/tetris_input_ctrl_if.sv
// Keycode bus between the USB GPIO side and the input controller.
//   keycode      : four raw HID keycode slots (GPIO side drives)
//   cmd_keycode  : filtered command for the current frame (controller drives)
//   cmd_valid    : one-cycle pulse when cmd_keycode is refreshed
//   held_mask    : debug snapshot {hard, rot, soft, right, left}
// master = GPIO / game-logic side, slave = tetris_input_ctrl.
interface tetris_input_ctrl_if;
    import tetris_input_pkg::*;

    logic [31:0] keycode;
    logic [7:0]  cmd_keycode;
    logic        cmd_valid;
    logic [4:0]  held_mask;

    modport master (output keycode, input cmd_keycode, input cmd_valid, input held_mask);
    modport slave  (input keycode, output cmd_keycode, output cmd_valid, output held_mask);

endinterface

// File: rtl/key_repeat_unit.sv
// Delayed-auto-shift / auto-repeat unit for one key, advanced once per frame strobe.
//   held, press : key level and press edge from the current frame snapshot
//   strobe      : one-cycle frame strobe; state only moves on this cycle
//   force_idle  : park the unit in IDLE without firing (left+right conflict)
//   fire        : combinational fire request, only asserted during strobe
// USE_DAS = 0 skips the initial delay and goes straight to REPEAT.
module key_repeat_unit
    import tetris_input_pkg::*;
#(
    parameter bit USE_DAS   = 1'b1,
    parameter int DAS_DELAY = 10,
    parameter int PERIOD    = 3,
    parameter int CNT_W     = 6
) (
    input  logic Clk,
    input  logic reset_rtl_0,
    input  logic held,
    input  logic press,
    input  logic strobe,
    input  logic force_idle,
    output logic fire
);

    localparam logic [CNT_W-1:0] DAS_LAST = CNT_W'(DAS_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    rpt_state_t       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;

    // Saturating increment: a stuck key never wraps the counter.
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

    always_ff @(posedge Clk) begin
        if (!reset_rtl_0) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (strobe) begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        fire    = 1'b0;
        if (force_idle) begin
            state_n = IDLE;
            cnt_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (press) begin
                        fire  = strobe;
                        cnt_n = '0;
                        if (USE_DAS) state_n = DAS;
                        else         state_n = REPEAT;
                    end
                end
                DAS: begin
                    if (!held) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end else if (cnt == DAS_LAST) begin
                        fire    = strobe;
                        cnt_n   = '0;
                        state_n = REPEAT;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end
                REPEAT: begin
                    if (!held) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end else if (cnt == PER_LAST) begin
                        fire  = strobe;
                        cnt_n = '0;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/tetris_input_ctrl.sv
// Input conditioning between the USB keycode GPIO and the Tetris game logic.
// Once per video frame it snapshots the HID slots, detects presses, applies
// DAS/auto-repeat to left/right/soft-drop and picks at most one command.
//   Clk         : 100 MHz system clock
//   reset_rtl_0 : synchronous active-low reset
//   frame_clk   : vsync, asynchronous to Clk
//   bus         : keycode in; cmd_keycode / cmd_valid / held_mask out
module tetris_input_ctrl
    import tetris_input_pkg::*;
#(
    parameter int DAS_DELAY   = 10,
    parameter int ARR_PERIOD  = 3,
    parameter int SOFT_PERIOD = 2,
    parameter int CNT_W       = 6
) (
    input  logic               Clk,
    input  logic               reset_rtl_0,
    input  logic               frame_clk,
    tetris_input_ctrl_if.slave bus
);

    logic       frame_sync_p0, frame_sync_p1, frame_sync_p2;
    logic       strobe;
    logic       rollover;
    logic [4:0] snap_raw, snap, prev_snap;
    logic       press_left, press_right, press_soft, press_rot, press_hard;
    logic       lr_both;
    logic       fire_left, fire_right, fire_soft;
    logic       pending_rot, pending_hard, pend_rot, pend_hard;
    logic       clr_rot, clr_hard;
    logic [7:0] cmd_n, cmd_keycode_r;
    logic       cmd_valid_r;

    // Stage p0/p1: two-flop synchronizer; p2: edge register for the strobe.
    always_ff @(posedge Clk) begin
        if (!reset_rtl_0) begin
            frame_sync_p0 <= 1'b0;
            frame_sync_p1 <= 1'b0;
            frame_sync_p2 <= 1'b0;
        end else begin
            frame_sync_p0 <= frame_clk;
            frame_sync_p1 <= frame_sync_p0;
            frame_sync_p2 <= frame_sync_p1;
        end
    end

    assign strobe = frame_sync_p1 & ~frame_sync_p2;

    // Snapshot bit order {hard, rot, soft, right, left}.
    assign snap_raw = {key_in_slots(bus.keycode, KC_HARD),
                       key_in_slots(bus.keycode, KC_ROT),
                       key_in_slots(bus.keycode, KC_SOFT),
                       key_in_slots(bus.keycode, KC_RIGHT),
                       key_in_slots(bus.keycode, KC_LEFT)};

    // Keyboard rollover reports garbage in every slot; keep the last good view.
    assign rollover = (bus.keycode[7:0]   == KC_ROLLOVER) && (bus.keycode[15:8]  == KC_ROLLOVER) &&
                      (bus.keycode[23:16] == KC_ROLLOVER) && (bus.keycode[31:24] == KC_ROLLOVER);
    assign snap     = rollover ? prev_snap : snap_raw;

    assign lr_both = snap[0] & snap[1];

    // A left/right key surviving a left+right chord counts as a fresh press,
    // since its unit was parked in IDLE while both were down.
    assign press_left  = snap[0] & (~prev_snap[0] | prev_snap[1]);
    assign press_right = snap[1] & (~prev_snap[1] | prev_snap[0]);
    assign press_soft  = snap[2] & ~prev_snap[2];
    assign press_rot   = snap[3] & ~prev_snap[3];
    assign press_hard  = snap[4] & ~prev_snap[4];

    key_repeat_unit #(.USE_DAS(1'b1), .DAS_DELAY(DAS_DELAY), .PERIOD(ARR_PERIOD), .CNT_W(CNT_W)) u_left (
        .Clk(Clk), .reset_rtl_0(reset_rtl_0), .held(snap[0]), .press(press_left),
        .strobe(strobe), .force_idle(lr_both), .fire(fire_left));

    key_repeat_unit #(.USE_DAS(1'b1), .DAS_DELAY(DAS_DELAY), .PERIOD(ARR_PERIOD), .CNT_W(CNT_W)) u_right (
        .Clk(Clk), .reset_rtl_0(reset_rtl_0), .held(snap[1]), .press(press_right),
        .strobe(strobe), .force_idle(lr_both), .fire(fire_right));

    key_repeat_unit #(.USE_DAS(1'b0), .DAS_DELAY(DAS_DELAY), .PERIOD(SOFT_PERIOD), .CNT_W(CNT_W)) u_soft (
        .Clk(Clk), .reset_rtl_0(reset_rtl_0), .held(snap[2]), .press(press_soft),
        .strobe(strobe), .force_idle(1'b0), .fire(fire_soft));

    // Pending flags include this frame's press so a same-frame press can win.
    assign pend_hard = pending_hard | press_hard;
    assign pend_rot  = pending_rot  | press_rot;

    always_comb begin
        cmd_n    = KC_NONE;
        clr_hard = 1'b0;
        clr_rot  = 1'b0;
        if (pend_hard) begin
            cmd_n    = KC_HARD;
            clr_hard = 1'b1;
        end else if (pend_rot) begin
            cmd_n   = KC_ROT;
            clr_rot = 1'b1;
        end else if (fire_left) begin
            cmd_n = KC_LEFT;
        end else if (fire_right) begin
            cmd_n = KC_RIGHT;
        end else if (fire_soft) begin
            cmd_n = KC_SOFT;
        end
    end

    // Strobe stage: commit snapshot, pending flags and the frame's command.
    always_ff @(posedge Clk) begin
        if (!reset_rtl_0) begin
            prev_snap     <= '0;
            pending_hard  <= 1'b0;
            pending_rot   <= 1'b0;
            cmd_keycode_r <= KC_NONE;
            cmd_valid_r   <= 1'b0;
        end else begin
            cmd_valid_r <= strobe;
            if (strobe) begin
                prev_snap     <= snap;
                pending_hard  <= pend_hard & ~clr_hard;
                pending_rot   <= pend_rot & ~clr_rot;
                cmd_keycode_r <= cmd_n;
            end
        end
    end

    assign bus.cmd_keycode = cmd_keycode_r;
    assign bus.cmd_valid   = cmd_valid_r;
    assign bus.held_mask   = prev_snap;

endmodule

// File: tb/tb_tetris_input_ctrl.sv
// Scoreboard bench for tetris_input_ctrl: each frame pushes its hand-computed
// command and held mask; a negedge monitor pops one entry per cmd_valid pulse.
module tb_tetris_input_ctrl;
    import tetris_input_pkg::*;

    typedef struct {
        string      tag;
        int         frame;
        logic [7:0] kc;
        logic [4:0] mask;
    } exp_t;

    logic Clk         = 1'b0;
    logic reset_rtl_0 = 1'b0;
    logic frame_clk   = 1'b0;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;

    tetris_input_ctrl_if bus();

    tetris_input_ctrl #(
        .DAS_DELAY(10), .ARR_PERIOD(3), .SOFT_PERIOD(2), .CNT_W(6)
    ) dut (
        .Clk(Clk),
        .reset_rtl_0(reset_rtl_0),
        .frame_clk(frame_clk),
        .bus(bus)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    // Monitor: one expected entry per output update.
    always @(negedge Clk) begin
        if (reset_rtl_0 && bus.cmd_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected cmd_valid: actual %0h required none", bus.cmd_keycode);
            end else begin
                mon_e = exp_q.pop_front();
                check($sformatf("%s f%0d cmd", mon_e.tag, mon_e.frame), bus.cmd_keycode, mon_e.kc);
                check($sformatf("%s f%0d mask", mon_e.tag, mon_e.frame), bus.held_mask, mon_e.mask);
            end
        end
    end

    task automatic do_reset(input logic [31:0] kc);
        bus.keycode = kc;
        frame_clk   = 1'b0;
        reset_rtl_0 = 1'b0;
        repeat (5) @(negedge Clk);
        check("reset cmd_keycode", bus.cmd_keycode, 0);
        check("reset cmd_valid", bus.cmd_valid, 0);
        check("reset held_mask", bus.held_mask, 0);
        reset_rtl_0 = 1'b1;
        @(negedge Clk);
    endtask

    task automatic do_frame(input string tag, input int f, input logic [31:0] kc,
                            input logic [7:0] ekc, input logic [4:0] emask);
        exp_t e;
        bit   got;
        e.tag  = tag;
        e.frame = f;
        e.kc   = ekc;
        e.mask = emask;
        bus.keycode = kc;
        exp_q.push_back(e);
        @(negedge Clk);
        frame_clk = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk);
            if (bus.cmd_valid) begin
                got = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!got) begin
            n_err++;
            $display("FAIL %s f%0d cmd_valid latency: actual none required within 6 clk", tag, f);
            e = exp_q.pop_back();
        end
        repeat (3) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (8) @(negedge Clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global timeout: actual running required finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] ekc;

        // Key held through reset is a new press on the first frame.
        do_reset(32'h0000_0004);
        do_frame("rst_hold", 0, 32'h0000_0004, KC_LEFT, 5'h01);

        // Right held 20 frames: DAS 10, ARR 3.
        do_reset(32'h0);
        for (int f = 0; f < 20; f++) begin
            ekc = (f == 0 || f == 10 || f == 13 || f == 16 || f == 19) ? KC_RIGHT : KC_NONE;
            do_frame("das_right", f, 32'h0000_0007, ekc, 5'h02);
        end

        // Hard + rot same frame: hard wins, rot stays pending one frame.
        do_reset(32'h0);
        do_frame("hard_rot", 0, 32'h2C1A_0000, KC_HARD, 5'h18);
        do_frame("hard_rot", 1, 32'h2C1A_0000, KC_ROT,  5'h18);
        do_frame("hard_rot", 2, 32'h2C1A_0000, KC_NONE, 5'h18);
        do_frame("hard_rot", 3, 32'h2C1A_0000, KC_NONE, 5'h18);
        do_frame("unknown",  4, 32'h0000_0055, KC_NONE, 5'h00);

        // Left + right chord, then release left.
        do_reset(32'h0);
        for (int f = 0; f < 5; f++)
            do_frame("lr_chord", f, 32'h0000_0704, KC_NONE, 5'h03);
        do_frame("lr_chord", 5, 32'h0000_0700, KC_RIGHT, 5'h02);
        do_frame("lr_chord", 6, 32'h0000_0700, KC_NONE,  5'h02);

        // Soft drop repeat, left press pre-empts soft fire at frame 2.
        do_reset(32'h0);
        do_frame("soft_left", 0, 32'h0000_0016, KC_SOFT, 5'h04);
        do_frame("soft_left", 1, 32'h0000_0016, KC_NONE, 5'h04);
        do_frame("soft_left", 2, 32'h0000_0416, KC_LEFT, 5'h05);
        do_frame("soft_left", 3, 32'h0000_0416, KC_NONE, 5'h05);
        do_frame("soft_left", 4, 32'h0000_0416, KC_SOFT, 5'h05);
        do_frame("soft_left", 5, 32'h0000_0416, KC_NONE, 5'h05);

        // Rollover frame during left DAS must not restart the delay.
        do_reset(32'h0);
        for (int f = 0; f < 12; f++) begin
            ekc = (f == 0 || f == 10) ? KC_LEFT : KC_NONE;
            do_frame("rollover", f, (f == 4) ? 32'h0101_0101 : 32'h0000_0004, ekc, 5'h01);
        end

        repeat (4) @(negedge Clk);
        check("scoreboard drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
